wbh_host_bridge: RTL and testbench

//  Downstream of the top-level wrapper's management-SoC Wishbone slave port, inside digital_core.

---
 rtl/wbh_pkg.sv | 12 +
 rtl/wbh_regs.sv | 42 ++++
 rtl/wbh_host_bridge.sv | 100 ++++++++++
 tb/tb_wbh_host_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wbh_pkg.sv
// wbh_pkg: shared FSM states, address window/decode constants and STATUS bit positions
// for the wbh_host_bridge slice.
package wbh_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXT = 2'd1, ST_RESP = 2'd2} wbh_state_e;
   localparam logic [7:0] WIN_ADR    = 8'h30;
   localparam logic [1:0] LOC_SEL    = 2'b11;
   localparam logic [7:0] OFF_BANK   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_ID     = 8'h08;
   localparam int         STAT_TO    = 0;
   localparam int         STAT_ERR   = 1;
endpackage

// File: rtl/wbh_regs.sv
// wbh_regs: BANK/STATUS/ID local registers with W1C status and read mux.
module wbh_regs
   import wbh_pkg::*;
#(
   parameter logic [31:0] CHIP_ID = 32'h5249_5343
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr,
   input  logic [7:0]  i_off,
   input  logic [7:0]  i_wdat,
   input  logic        i_sel0,
   input  logic        i_set_to,
   input  logic        i_set_err,
   output logic [7:0]  o_bank,
   output logic [31:0] o_rdata
);
   logic [7:0] r_bank;
   logic [1:0] r_status;
   logic [1:0] w_set;
   logic [1:0] w_clr;
   always_comb begin
      w_set = '0;
      w_set[STAT_TO]  = i_set_to;
      w_set[STAT_ERR] = i_set_err;
   end
   assign w_clr = (i_wr && i_off == OFF_STATUS) ? i_wdat[1:0] : 2'b00;
   // set events are OR'ed after the clear so they win over a same-cycle W1C
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bank   <= '0;
         r_status <= '0;
      end else begin
         r_bank   <= (i_wr && i_sel0 && i_off == OFF_BANK) ? i_wdat : r_bank;
         r_status <= w_set | (r_status & ~w_clr);
      end
   end
   assign o_bank  = r_bank;
   assign o_rdata = (i_off == OFF_BANK)   ? {24'd0, r_bank}   :
                    (i_off == OFF_STATUS) ? {30'd0, r_status} :
                    (i_off == OFF_ID)     ? CHIP_ID           : 32'd0;
endmodule

// File: rtl/wbh_host_bridge.sv
// wbh_host_bridge: registers Caravel Wishbone requests and replays them as one banked internal cycle.
// Define WBH_TIMEOUT_EN to add the bounded-wait timeout on the internal slave.
module wbh_host_bridge
   import wbh_pkg::*;
#(
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] CHIP_ID     = 32'h5249_5343,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic [7:0]  bank_o
);
   wbh_state_e  r_state;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [23:0] r_adr;
   logic [31:0] r_dat;
   logic [31:0] r_rdata;
   logic        w_req, w_win, w_loc, w_ext, w_ack, w_err, w_to;
   logic [31:0] w_reg_rdata;
   assign w_req = (r_state == ST_IDLE) && wbs_cyc_i && wbs_stb_i;
   assign w_win = wbs_adr_i[31:24] == WIN_ADR;
   assign w_loc = w_win && wbs_adr_i[23:22] == LOC_SEL;
   assign w_ext = r_state == ST_EXT;
   assign w_ack = w_ext && wbm_ack_i;
   assign w_err = w_ext && wbm_err_i;
`ifdef WBH_TIMEOUT_EN
   logic [7:0] r_cnt;
   // r_cnt holds the number of EXT cycles already completed, so this fires on the TIMEOUT_CYC-th one
   assign w_to = w_ext && !wbm_ack_i && !wbm_err_i && (r_cnt + 8'd1 == 8'(TIMEOUT_CYC));
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) r_cnt <= '0;
      else           r_cnt <= w_ext ? r_cnt + 8'd1 : 8'd0;
   end
`else
   logic w_unused;
   assign w_to     = 1'b0;
   assign w_unused = TIMEOUT_CYC == 0;
`endif
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_rdata <= '0;
      end else if (w_req) begin
         r_we    <= wbs_we_i;
         r_sel   <= wbs_sel_i;
         r_adr   <= wbs_adr_i[23:0];
         r_dat   <= wbs_dat_i;
         r_state <= (w_win && !w_loc) ? ST_EXT : ST_RESP;
         r_rdata <= (w_loc && !wbs_we_i) ? w_reg_rdata : 32'd0;
      end else if (w_ack || w_err || w_to) begin
         r_state <= ST_RESP;
         r_rdata <= r_we ? 32'd0 : (w_ack && !w_err) ? wbm_dat_i : ERR_DATA;
      end else if (r_state == ST_RESP) begin
         r_state <= ST_IDLE;
      end
   end
   wbh_regs #(.CHIP_ID(CHIP_ID)) u_regs (
      .i_clk    (wb_clk_i),
      .i_rst_n  (wb_rst_n),
      .i_wr     (w_req && w_loc && wbs_we_i),
      .i_off    (wbs_adr_i[7:0]),
      .i_wdat   (wbs_dat_i[7:0]),
      .i_sel0   (wbs_sel_i[0]),
      .i_set_to (w_to),
      .i_set_err(w_err),
      .o_bank   (bank_o),
      .o_rdata  (w_reg_rdata)
   );
   assign wbs_ack_o = r_state == ST_RESP;
   assign wbs_dat_o = wbs_ack_o ? r_rdata : 32'd0;
   assign wbm_cyc_o = w_ext;
   assign wbm_stb_o = w_ext;
   assign wbm_we_o  = w_ext && r_we;
   assign wbm_sel_o = w_ext ? r_sel : 4'd0;
   assign wbm_adr_o = w_ext ? {bank_o, r_adr} : 32'd0;
   assign wbm_dat_o = w_ext ? r_dat : 32'd0;
endmodule

// File: tb/tb_wbh_host_bridge.sv
// tb_wbh_host_bridge: randomized self-checking bench for wbh_host_bridge against a transaction-level model.
// Timeout scenario is only exercised when WBH_TIMEOUT_EN is defined.
module tb_wbh_host_bridge;
   localparam int          TO  = 255;
   localparam logic [31:0] ID  = 32'h5249_5343;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   logic        clk = 0, rst_n = 0;
   logic        cyc = 0, stb = 0, we_i = 0;
   logic [3:0]  sel_i = 0;
   logic [31:0] adr_i = 0, dat_i = 0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] m_dat = 0;
   logic        m_ack = 0, m_err = 0;
   logic [7:0]  bank_o;
   int          n_cmp = 0, n_bad = 0;
   logic [7:0]  m_bank = 0;
   logic [1:0]  m_status = 0;
   always #5 clk = ~clk;
   wbh_host_bridge dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
      .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(m_dat),
      .wbm_ack_i(m_ack), .wbm_err_i(m_err), .bank_o(bank_o)
   );
   // kind: 0 ack, 1 err, 2 ack+err together, 3 silent slave; response after dly idle EXT cycles
   task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr, wdat,
                       input int kind, dly, input logic [31:0] sdat,
                       output logic got, output logic [31:0] rd, output int lat, output int ecyc,
                       output logic [31:0] madr, mdat, output logic mwe, output logic [3:0] msel,
                       output logic stable, output logic onepulse);
      got = 0; rd = 0; lat = 0; ecyc = 0; madr = 0; mdat = 0; mwe = 0; msel = 0; stable = 1; onepulse = 1;
      @(negedge clk);
      cyc = 1; stb = 1; we_i = we; sel_i = sel; adr_i = adr; dat_i = wdat;
      for (int n = 1; n <= 400 && !got; n++) begin
         @(negedge clk);
         m_ack = 0; m_err = 0;
         if (wbs_ack_o) begin
            got = 1; rd = wbs_dat_o; lat = n;
            if (wbm_cyc_o) stable = 0;
            cyc = 0; stb = 0;
         end else if (wbm_cyc_o) begin
            ecyc++;
            if (ecyc == 1) begin
               madr = wbm_adr_o; mdat = wbm_dat_o; mwe = wbm_we_o; msel = wbm_sel_o;
               if (!wbm_stb_o) stable = 0;
            end else if ({wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o} !== {madr, mdat, mwe, msel, 1'b1})
               stable = 0;
            if (ecyc == dly + 1 && kind != 3) begin
               m_ack = kind != 1; m_err = kind != 0; m_dat = (kind == 0) ? sdat : $urandom;
            end
         end
      end
      if (got) begin
         @(negedge clk);
         onepulse = !wbs_ack_o;
      end else begin
         cyc = 0; stb = 0;
      end
   endtask
   task automatic check_xfer(input string nm, input logic we, input logic [3:0] sel, input logic [31:0] adr, wdat,
                             input int kind, dly, input logic [31:0] sdat);
      logic win, loc, ext, got, mwe, stable, onepulse;
      logic [7:0] off;
      logic [3:0] msel;
      logic [31:0] e_rd, e_madr, rd, madr, mdat;
      int e_lat, e_ecyc, lat, ecyc;
      win = adr[31:24] == 8'h30; loc = win && adr[23:22] == 2'b11; ext = win && !loc; off = adr[7:0];
      e_madr = {m_bank, adr[23:0]};
      if (ext) begin
         e_ecyc = (kind == 3) ? TO : dly + 1;
         e_lat  = e_ecyc + 1;
         e_rd   = we ? 32'd0 : (kind == 0) ? sdat : ERR;
      end else begin
         e_ecyc = 0; e_lat = 1;
         e_rd = (!loc || we) ? 32'd0 : (off == 8'h00) ? {24'd0, m_bank} : (off == 8'h04) ? {30'd0, m_status} :
                (off == 8'h08) ? ID : 32'd0;
      end
      xfer(we, sel, adr, wdat, kind, dly, sdat, got, rd, lat, ecyc, madr, mdat, mwe, msel, stable, onepulse);
      if (ext && kind == 3) m_status[0] = 1'b1;
      if (ext && (kind == 1 || kind == 2)) m_status[1] = 1'b1;
      if (loc && we && off == 8'h00 && sel[0]) m_bank = wdat[7:0];
      if (loc && we && off == 8'h04) m_status = m_status & ~wdat[1:0];
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL %s ack_seen got=%0b want=1", nm, got); end
      n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL %s rdata got=%h want=%h", nm, rd, e_rd); end
      n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, e_lat); end
      n_cmp++; if (ecyc !== e_ecyc) begin n_bad++; $display("FAIL %s ext_cycles got=%0d want=%0d", nm, ecyc, e_ecyc); end
      n_cmp++; if (onepulse !== 1'b1) begin n_bad++; $display("FAIL %s ack_one_cycle got=%0b want=1", nm, onepulse); end
      n_cmp++; if (bank_o !== m_bank) begin n_bad++; $display("FAIL %s bank got=%h want=%h", nm, bank_o, m_bank); end
      if (ext) begin
         n_cmp++; if (madr !== e_madr) begin n_bad++; $display("FAIL %s wbm_adr got=%h want=%h", nm, madr, e_madr); end
         n_cmp++; if (mdat !== wdat) begin n_bad++; $display("FAIL %s wbm_dat got=%h want=%h", nm, mdat, wdat); end
         n_cmp++; if ({mwe, msel} !== {we, sel}) begin n_bad++; $display("FAIL %s wbm_we_sel got=%b want=%b", nm, {mwe, msel}, {we, sel}); end
         n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL %s wbm_stable got=%0b want=1", nm, stable); end
      end
   endtask
   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({wbs_ack_o, wbs_dat_o} !== 33'd0) begin n_bad++; $display("FAIL reset wbs got=%h want=0", {wbs_ack_o, wbs_dat_o}); end
      n_cmp++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'd0) begin
         n_bad++; $display("FAIL reset wbm got=%h want=0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}); end
      n_cmp++; if (bank_o !== 8'd0) begin n_bad++; $display("FAIL reset bank got=%h want=0", bank_o); end
      rst_n = 1;
      m_bank = 0; m_status = 0;
      check_xfer("reset_status", 1'b0, 4'hF, 32'h30C0_0004, 32'd0, 0, 0, 32'd0);
   endtask
   task automatic test_ext_write();
      check_xfer("ext_write", 1'b1, 4'hF, 32'h3000_0010, 32'h1234_5678, 0, 3, 32'd0);
   endtask
   task automatic test_bank_read();
      check_xfer("bank_write", 1'b1, 4'hF, 32'h30C0_0000, 32'h0000_005A, 0, 0, 32'd0);
      check_xfer("bank_readback", 1'b0, 4'hF, 32'h30C0_0000, 32'd0, 0, 0, 32'd0);
      check_xfer("banked_read", 1'b0, 4'hF, 32'h3000_0004, 32'd0, 0, 2, 32'hCAFE_F00D);
      check_xfer("bank_sel_gated", 1'b1, 4'hE, 32'h30C0_0000, 32'h0000_0011, 0, 0, 32'd0);
   endtask
   task automatic test_local_id();
      check_xfer("id_read", 1'b0, 4'hF, 32'h30C0_0008, 32'd0, 0, 0, 32'd0);
      check_xfer("unmapped_read", 1'b0, 4'hF, 32'h30C0_000C, 32'd0, 0, 0, 32'd0);
      check_xfer("out_of_window", 1'b0, 4'hF, 32'h2000_0010, 32'd0, 0, 0, 32'd0);
   endtask
`ifdef WBH_TIMEOUT_EN
   task automatic test_timeout();
      check_xfer("timeout_read", 1'b0, 4'hF, 32'h3000_0100, 32'd0, 3, 0, 32'd0);
      check_xfer("timeout_status", 1'b0, 4'hF, 32'h30C0_0004, 32'd0, 0, 0, 32'd0);
      check_xfer("status_w1c", 1'b1, 4'hF, 32'h30C0_0004, 32'd1, 0, 0, 32'd0);
      check_xfer("status_cleared", 1'b0, 4'hF, 32'h30C0_0004, 32'd0, 0, 0, 32'd0);
   endtask
`endif
   task automatic test_err();
      check_xfer("err_only", 1'b0, 4'hF, 32'h3000_0020, 32'd0, 1, 1, 32'd0);
      check_xfer("err_and_ack", 1'b0, 4'hF, 32'h3000_0024, 32'd0, 2, 0, 32'h1111_2222);
      check_xfer("err_status", 1'b0, 4'hF, 32'h30C0_0004, 32'd0, 0, 0, 32'd0);
      check_xfer("err_w1c", 1'b1, 4'hF, 32'h30C0_0004, 32'd2, 0, 0, 32'd0);
      check_xfer("err_status_clr", 1'b0, 4'hF, 32'h30C0_0004, 32'd0, 0, 0, 32'd0);
   endtask
   task automatic test_random();
      logic [31:0] adr;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    adr = {8'h30, 2'($urandom_range(0, 2)), 22'($urandom)};
            2:       adr = {8'h30, 2'b11, 14'($urandom), 8'($urandom_range(0, 3) * 4)};
            default: begin adr = $urandom; if (adr[31:24] == 8'h30) adr[31:24] = 8'h31; end
         endcase
         check_xfer("random", 1'($urandom), 4'($urandom), adr, $urandom, $urandom_range(0, 2), $urandom_range(0, 5), $urandom);
      end
   endtask
   task automatic test_reset_mid();
      logic seen;
      check_xfer("pre_bank", 1'b1, 4'hF, 32'h30C0_0000, 32'h0000_00A5, 0, 0, 32'd0);
      seen = 0;
      @(negedge clk);
      cyc = 1; stb = 1; we_i = 0; sel_i = 4'hF; adr_i = 32'h3000_0040;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = wbm_cyc_o;
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_reset ext_entered got=%0b want=1", seen); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if ({wbm_cyc_o, wbs_ack_o} !== 2'b00) begin n_bad++; $display("FAIL mid_reset cyc_ack got=%b want=00", {wbm_cyc_o, wbs_ack_o}); end
      n_cmp++; if (bank_o !== 8'd0) begin n_bad++; $display("FAIL mid_reset bank got=%h want=0", bank_o); end
      cyc = 0; stb = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset no_ack got=%0b want=0", wbs_ack_o); end
      rst_n = 1;
      m_bank = 0; m_status = 0;
      check_xfer("post_reset_write", 1'b1, 4'hF, 32'h3000_0010, 32'h1234_5678, 0, 3, 32'd0);
   endtask
   initial begin
      test_reset();
      test_ext_write();
      test_bank_read();
      test_local_id();
`ifdef WBH_TIMEOUT_EN
      test_timeout();
`endif
      test_err();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
